// File: rtl/ib_mul_16x16_seq.sv
// Sequential 16x16 unsigned multiplier: one shared 8x8 array, four partial products
// shift-accumulated into a 32-bit result, valid/ready in, valid/ack out.
module ib_mul_16x16_seq (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic        o_valid,
   input  logic        i_ack,
   output logic [31:0] o_c
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_P0   = 3'd1,
      ST_P1   = 3'd2,
      ST_P2   = 3'd3,
      ST_P3   = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   // The single shared 8x8 unsigned array.
   function automatic logic [15:0] mul8x8(input logic [7:0] x, input logic [7:0] y);
      mul8x8 = 16'(x) * 16'(y);
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic [15:0] a_r;
   logic [15:0] b_r;
   logic [31:0] acc_r;
   logic [31:0] c_r;
   logic        valid_r;
   logic        ready_r;
   logic [7:0]  mul_a_s;
   logic [7:0]  mul_b_s;
   logic [15:0] prod_s;
   logic [31:0] addend_s;

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_valid) state_nxt_s = ST_P0;
            else         state_nxt_s = ST_IDLE;
         end
         ST_P0:   state_nxt_s = ST_P1;
         ST_P1:   state_nxt_s = ST_P2;
         ST_P2:   state_nxt_s = ST_P3;
         ST_P3:   state_nxt_s = ST_DONE;
         ST_DONE: begin
            if (i_ack) state_nxt_s = ST_IDLE;
            else       state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Operand-half muxes and the shifted, zero-extended partial product; the addend is zero outside P0..P3.
   always_comb begin
      mul_a_s  = a_r[7:0];
      mul_b_s  = b_r[7:0];
      addend_s = 32'd0;
      case (state_r)
         ST_P0: begin
            mul_a_s  = a_r[7:0];
            mul_b_s  = b_r[7:0];
            addend_s = {16'd0, prod_s};
         end
         ST_P1: begin
            mul_a_s  = a_r[15:8];
            mul_b_s  = b_r[7:0];
            addend_s = {8'd0, prod_s, 8'd0};
         end
         ST_P2: begin
            mul_a_s  = a_r[7:0];
            mul_b_s  = b_r[15:8];
            addend_s = {8'd0, prod_s, 8'd0};
         end
         ST_P3: begin
            mul_a_s  = a_r[15:8];
            mul_b_s  = b_r[15:8];
            addend_s = {prod_s, 16'd0};
         end
         default: begin
            mul_a_s  = a_r[7:0];
            mul_b_s  = b_r[7:0];
            addend_s = 32'd0;
         end
      endcase
   end

   assign prod_s = mul8x8(mul_a_s, mul_b_s);

   // State, operands, accumulator and registered outputs; reset overrides everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         a_r     <= 16'd0;
         b_r     <= 16'd0;
         acc_r   <= 32'd0;
         c_r     <= 32'd0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s == ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (i_valid) begin
                  a_r   <= i_a;
                  b_r   <= i_b;
                  acc_r <= 32'd0;
               end else begin
                  acc_r <= acc_r;
               end
            end
            ST_P0, ST_P1, ST_P2: acc_r <= acc_r + addend_s;
            ST_P3: begin
               c_r     <= acc_r + addend_s;
               valid_r <= 1'b1;
            end
            ST_DONE: begin
               if (i_ack) valid_r <= 1'b0;
               else       valid_r <= 1'b1;
            end
            default: valid_r <= 1'b0;
         endcase
      end
   end

   assign o_ready = ready_r;
   assign o_valid = valid_r;
   assign o_c     = c_r;

endmodule

// File: tb/tb_ib_mul_16x16_seq.sv
// Self-checking bench for ib_mul_16x16_seq: directed cases plus random operands
// against a plain 32-bit arithmetic reference with random acknowledge delays.
module tb_ib_mul_16x16_seq;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        o_valid;
   logic        i_ack;
   logic [31:0] o_c;

   int checks = 0;
   int errors = 0;

   ib_mul_16x16_seq dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_b     (i_b),
      .o_valid (o_valid),
      .i_ack   (i_ack),
      .o_c     (o_c)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One full transaction: accept, wait for the result, hold it for ack_delay cycles, then acknowledge.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int ack_delay,
                         input bit ack_tied, input bit hold_valid, input bit rnd);
      logic [31:0] exp_c;
      int          lat;
      exp_c = 32'(a) * 32'(b);
      check("ready_idle", {31'd0, o_ready}, 32'd1);
      i_a     = a;
      i_b     = b;
      i_valid = 1'b1;
      i_ack   = ack_tied;
      tick();
      if (!hold_valid) i_valid = 1'b0;
      check("ready_busy", {31'd0, o_ready}, 32'd0);
      check("valid_busy", {31'd0, o_valid}, 32'd0);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         i_a = rnd ? 16'($urandom) : 16'hFFFF;
         i_b = rnd ? 16'($urandom) : 16'hFFFF;
         tick();
         if (o_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      check("latency", 32'(lat), 32'd4);
      check("product", o_c, exp_c);
      for (int k = 0; k < ack_delay; k++) begin
         i_a = 16'($urandom);
         i_b = 16'($urandom);
         tick();
         check("bp_valid", {31'd0, o_valid}, 32'd1);
         check("bp_ready", {31'd0, o_ready}, 32'd0);
         check("bp_product", o_c, exp_c);
      end
      i_ack = 1'b1;
      tick();
      i_ack   = 1'b0;
      i_valid = 1'b0;
      check("valid_after_ack", {31'd0, o_valid}, 32'd0);
      check("ready_after_ack", {31'd0, o_ready}, 32'd1);
      check("c_held", o_c, exp_c);
   endtask

   initial begin
      // Reset with a request pending: it must not be accepted.
      i_rst   = 1'b1;
      i_valid = 1'b1;
      i_ack   = 1'b0;
      i_a     = 16'h1111;
      i_b     = 16'h2222;
      tick();
      tick();
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      check("rst_valid", {31'd0, o_valid}, 32'd0);
      check("rst_c", o_c, 32'd0);
      i_rst   = 1'b0;
      i_valid = 1'b0;
      tick();
      check("no_accept_in_reset", {31'd0, o_ready}, 32'd1);

      run_op(16'h1234, 16'h5678, 0, 1'b1, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 0, 1'b0, 1'b0, 1'b0);
      run_op(16'h0000, 16'hABCD, 0, 1'b0, 1'b0, 1'b0);
      run_op(16'h00FF, 16'h0100, 1, 1'b0, 1'b0, 1'b0);
      run_op(16'h8000, 16'h0002, 10, 1'b0, 1'b1, 1'b1);

      // Reset during P2 discards the operation.
      i_a     = 16'hFFFF;
      i_b     = 16'hFFFF;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick();
      tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("midrst_valid", {31'd0, o_valid}, 32'd0);
      check("midrst_c", o_c, 32'd0);
      check("midrst_ready", {31'd0, o_ready}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("midrst_quiet", {31'd0, o_valid}, 32'd0);
      end
      run_op(16'h0003, 16'h0005, 0, 1'b0, 1'b0, 1'b0);

      run_op(16'h0010, 16'h0010, 2, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 5)),
                1'b0, 1'($urandom_range(0, 1)), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
